// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, FSM states, SKIPCOND codes and ALU modes for the accumulator CPU
package cpu_pkg;

    localparam logic [3:0] OP_LOAD     = 4'h1;
    localparam logic [3:0] OP_STORE    = 4'h2;
    localparam logic [3:0] OP_ADD      = 4'h3;
    localparam logic [3:0] OP_SUBT     = 4'h4;
    localparam logic [3:0] OP_SKIPCOND = 4'h5;
    localparam logic [3:0] OP_HALT     = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h9;
    localparam logic [3:0] OP_CLEAR    = 4'hA;

    localparam logic [1:0] SKIP_NEG   = 2'b00;
    localparam logic [1:0] SKIP_ZERO  = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_A,
        ST_FETCH_W,
        ST_DECODE,
        ST_OPER_A,
        ST_OPER_W,
        ST_EXEC,
        ST_STORE,
        ST_HALTED
    } state_t;

    // AC is treated as signed: ac_neg is its sign bit, ac_zero means all bits clear.
    function automatic logic skip_taken(input logic [1:0] cond, input logic ac_neg,
                                        input logic ac_zero);
        logic taken;
        taken = 1'b0;
        case (cond)
            SKIP_NEG:   taken = ac_neg;
            SKIP_ZERO:  taken = ac_zero;
            SKIP_POS:   taken = !ac_neg && !ac_zero;
            SKIP_NEVER: taken = 1'b0;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/accumulator_control_unit.sv
// rtl/accumulator_control_unit.sv - multi-cycle fetch/decode/execute sequencer for the accumulator CPU
module accumulator_control_unit
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 28,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] alu_left,
    output logic [DATA_WIDTH-1:0] alu_right,
    output logic [3:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  busy,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] ac_out
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic [DATA_WIDTH-1:0] ir_q, mbr_q;

    logic [3:0]            opcode;
    logic [1:0]            cond;
    logic [ADDR_WIDTH-1:0] ir_addr;

    assign opcode  = ir_q[DATA_WIDTH-1 -: 4];
    assign cond    = ir_q[ADDR_WIDTH-1 -: 2];
    assign ir_addr = ir_q[ADDR_WIDTH-1:0];

    assign alu_left    = ac_q;
    assign alu_right   = mbr_q;
    assign alu_control = (state_q == ST_EXEC && opcode == OP_SUBT) ? ALU_SUB : ALU_ADD;

    assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign halted = (state_q == ST_HALTED);
    assign pc_out = pc_q;
    assign ac_out = ac_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ac_d    = ac_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_FETCH_A;
                    pc_d    = RESET_PC;
                end
            end
            ST_FETCH_A: state_d = ST_FETCH_W;
            ST_FETCH_W: begin
                state_d = ST_DECODE;
                pc_d    = pc_q + 1'b1;
            end
            ST_DECODE: begin
                state_d = ST_FETCH_A;
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUBT: state_d = ST_OPER_A;
                    OP_STORE:                 state_d = ST_STORE;
                    OP_HALT:                  state_d = ST_HALTED;
                    OP_SKIPCOND: begin
                        if (skip_taken(cond, ac_q[DATA_WIDTH-1], ac_q == '0))
                            pc_d = pc_q + 1'b1;
                    end
                    OP_JUMP:  pc_d = ir_addr;
                    OP_CLEAR: ac_d = '0;
                    default:  ;
                endcase
            end
            ST_OPER_A: state_d = ST_OPER_W;
            ST_OPER_W: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH_A;
                ac_d    = (opcode == OP_LOAD) ? mbr_q : alu_out;
            end
            ST_STORE: state_d = ST_FETCH_A;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory strobes and MAR are loaded on entry to a memory state, so the synchronous
    // RAM sees a stable address and strobe for the whole state and the async reset kills
    // an in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            ac_q      <= '0;
            ir_q      <= '0;
            mbr_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            if (state_q == ST_FETCH_W) ir_q  <= mem_rdata;
            if (state_q == ST_OPER_W)  mbr_q <= mem_rdata;
            if (state_d == ST_FETCH_A)
                mem_addr <= pc_d;
            else if (state_d == ST_OPER_A || state_d == ST_STORE)
                mem_addr <= ir_addr;
            if (state_d == ST_STORE) mem_wdata <= ac_q;
            mem_cs <= (state_d == ST_FETCH_A) || (state_d == ST_OPER_A) || (state_d == ST_STORE);
            mem_oe <= (state_d == ST_FETCH_A) || (state_d == ST_OPER_A);
            mem_we <= (state_d == ST_STORE);
        end
    end

endmodule

// File: tb/tb_accumulator_control_unit.sv
// tb/tb_accumulator_control_unit.sv - self-checking bench for accumulator_control_unit
module tb_accumulator_control_unit;

    localparam logic [3:0] ADD_CODE = 4'b0010;
    localparam logic [3:0] SUB_CODE = 4'b0110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [27:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_cs, mem_we, mem_oe;
    logic [31:0] alu_left, alu_right, alu_out;
    logic [3:0]  alu_control;
    logic        busy, halted;
    logic [27:0] pc_out;
    logic [31:0] ac_out;

    int total = 0;
    int bad = 0;

    logic [31:0] mem  [logic [27:0]];
    logic [31:0] mref [logic [27:0]];
    logic [31:0] m_ac;

    accumulator_control_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .alu_left(alu_left), .alu_right(alu_right), .alu_control(alu_control),
        .alu_out(alu_out), .busy(busy), .halted(halted),
        .pc_out(pc_out), .ac_out(ac_out)
    );

    always #5 clk = ~clk;

    assign alu_out = (alu_control == SUB_CODE) ? alu_left - alu_right : alu_left + alu_right;

    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr] = mem_wdata;
        if (mem_cs && mem_oe) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (rst_n && mem_oe && mem_we) check("oe_we_exclusive", 1, 0);

    function automatic logic [31:0] rd(input logic [27:0] a);
        return mref.exists(a) ? mref[a] : 32'h0;
    endfunction

    // Instruction-level model: memory image + AC in, final AC/PC/cycle count out.
    task automatic model_run(output logic [27:0] pc_o, output int cyc_o);
        logic [27:0] pc;
        logic [31:0] ir, ac;
        logic        take;
        int          cyc;
        pc = 28'h100; ac = m_ac; cyc = 1;
        for (int step = 0; step < 1000; step++) begin
            ir = rd(pc);
            pc = pc + 28'd1;
            if (ir[31:28] == 4'h7) begin cyc += 3; break; end
            case (ir[31:28])
                4'h1: begin ac = rd(ir[27:0]); cyc += 6; end
                4'h2: begin mref[ir[27:0]] = ac; cyc += 4; end
                4'h3: begin ac = ac + rd(ir[27:0]); cyc += 6; end
                4'h4: begin ac = ac - rd(ir[27:0]); cyc += 6; end
                4'h5: begin
                    case (ir[27:26])
                        2'b00: take = $signed(ac) < 0;
                        2'b01: take = (ac == 0);
                        2'b10: take = $signed(ac) > 0;
                        default: take = 1'b0;
                    endcase
                    if (take) pc = pc + 28'd1;
                    cyc += 3;
                end
                4'h9: begin pc = ir[27:0]; cyc += 3; end
                4'hA: begin ac = 0; cyc += 3; end
                default: cyc += 3;
            endcase
        end
        m_ac = ac; pc_o = pc; cyc_o = cyc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Counts posedges from the one that samples start up to the one that enters HALTED.
    task automatic run_prog(input int glitch_at, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!halted && cyc < 3000) begin
            if (cyc == glitch_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        if (!halted) check("halt_timeout", 0, 1);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] init_ac;
        logic [31:0] operand;
        logic [31:0] exp_ac;
        logic [27:0] exp_pc;
        int          exp_cyc;
    } vec_t;

    initial begin
        vec_t        vt [14];
        int          cyc;
        logic [27:0] mpc;
        int          mcyc;
        logic [3:0]  ops [8];

        vt[0]  = '{32'h5400_0000, 32'h0,         32'h0, 32'h0,         28'h104, 13};
        vt[1]  = '{32'h5000_0000, 32'h0,         32'h0, 32'h0,         28'h103, 13};
        vt[2]  = '{32'h5000_0000, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 28'h104, 13};
        vt[3]  = '{32'h5800_0000, 32'h5,         32'h0, 32'h5,         28'h104, 13};
        vt[4]  = '{32'h5800_0000, 32'h8000_0000, 32'h0, 32'h8000_0000, 28'h103, 13};
        vt[5]  = '{32'h5C00_0000, 32'h0,         32'h0, 32'h0,         28'h103, 13};
        vt[6]  = '{32'h9000_0300, 32'h1,         32'h0, 32'h1,         28'h301, 13};
        vt[7]  = '{32'hA000_0000, 32'h1234,      32'h0, 32'h0,         28'h103, 13};
        vt[8]  = '{32'hF000_0000, 32'h55,        32'h0, 32'h55,        28'h103, 13};
        vt[9]  = '{32'h4000_0200, 32'h3,         32'h5, 32'hFFFF_FFFE, 28'h103, 16};
        vt[10] = '{32'h3000_0200, 32'hFFFF_FFFF, 32'h2, 32'h1,         28'h103, 16};
        vt[11] = '{32'h1000_0200, 32'h9,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 28'h103, 16};
        vt[12] = '{32'h9FFF_FFFF, 32'h7,         32'h0, 32'h7,         28'h001, 16};
        vt[13] = '{32'h2000_0210, 32'h77,        32'h0, 32'h77,        28'h103, 14};

        // Reset state and first fetch
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc_out, 28'h100);
        check("rst_ac", ac_out, 0);
        check("rst_strobes", {mem_cs, mem_we, mem_oe}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_alu_ctl", alu_control, ADD_CODE);
        mem.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("fetch_addr", mem_addr, 28'h100);
        check("fetch_oe", {mem_cs, mem_oe, mem_we}, 3'b110);
        check("fetch_busy", busy, 1);
        repeat (2) @(posedge clk);
        #1 check("pc_after_fetch", pc_out, 28'h101);

        // Demo program, then again with a start pulse mid-run that must be ignored
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            mem.delete();
            mem[28'h100] = 32'h1000_0200; mem[28'h200] = 32'd7;
            mem[28'h101] = 32'h3000_0201; mem[28'h201] = 32'd5;
            mem[28'h102] = 32'h2000_0202; mem[28'h103] = 32'h7000_0000;
            run_prog(pass == 0 ? -1 : 4, cyc);
            check("demo_m202", mem.exists(28'h202) ? mem[28'h202] : 32'h0, 32'd12);
            check("demo_ac", ac_out, 32'd12);
            check("demo_halted", {halted, busy}, 2'b10);
            check("demo_cycles", cyc, 20);
        end

        // Single-instruction table: LOAD initial AC, the instruction, then HALT
        for (int i = 0; i < 14; i++) begin
            mem.delete();
            mem[28'h100] = 32'h1000_01F0;
            mem[28'h1F0] = vt[i].init_ac;
            mem[28'h101] = vt[i].instr;
            mem[28'h200] = vt[i].operand;
            mem[28'h102] = 32'h7000_0000;
            mem[28'h103] = 32'h7000_0000;
            mem[28'h300] = 32'h7000_0000;
            mem[28'h0]   = 32'h7000_0000;
            mem[28'hFFF_FFFF] = 32'hF000_0000;
            run_prog(-1, cyc);
            check($sformatf("vec%0d_ac", i), ac_out, vt[i].exp_ac);
            check($sformatf("vec%0d_pc", i), pc_out, vt[i].exp_pc);
            check($sformatf("vec%0d_cyc", i), cyc, vt[i].exp_cyc);
        end
        check("vec13_store", mem.exists(28'h210) ? mem[28'h210] : 32'h0, 32'h77);

        // Reset in the middle of a STORE
        do_reset();
        mem.delete();
        mem[28'h100] = 32'h1000_0200; mem[28'h200] = 32'h99;
        mem[28'h101] = 32'h2000_0250; mem[28'h102] = 32'h7000_0000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!mem_we && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("store_reached", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we_cs", {mem_we, mem_cs}, 0);
        check("rst_mid_state", {busy, halted}, 0);
        check("rst_mid_pc", pc_out, 28'h100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_nowrite", mem.exists(28'h250) ? mem[28'h250] : 32'h0, 0);

        // Random straight-line programs against the instruction-level model
        do_reset();
        m_ac = 32'h0;
        ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hA, 4'hF, 4'h0};
        for (int r = 0; r < 20; r++) begin
            mem.delete();
            for (int k = 0; k < 16; k++) begin
                case ($urandom_range(0, 3))
                    0: mem[28'h400 + 28'(k)] = 32'h0;
                    1: mem[28'h400 + 28'(k)] = 32'h8000_0000;
                    default: mem[28'h400 + 28'(k)] = $urandom;
                endcase
            end
            for (int k = 0; k < 12; k++) begin
                logic [3:0] op;
                op = ops[$urandom_range(0, 7)];
                if (op == 4'h5)
                    mem[28'h100 + 28'(k)] = {op, 2'($urandom_range(0, 3)), 26'h0};
                else
                    mem[28'h100 + 28'(k)] = {op, 28'h400 + 28'($urandom_range(0, 15))};
            end
            mem[28'h10C] = 32'h7000_0000;
            mem[28'h10D] = 32'h7000_0000;
            mref = mem;
            model_run(mpc, mcyc);
            run_prog(-1, cyc);
            check($sformatf("rnd%0d_ac", r), ac_out, m_ac);
            check($sformatf("rnd%0d_pc", r), pc_out, mpc);
            check($sformatf("rnd%0d_cyc", r), cyc, mcyc);
            for (int k = 0; k < 16; k++)
                check($sformatf("rnd%0d_m%0d", r, k), mem[28'h400 + 28'(k)], rd(28'h400 + 28'(k)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
